tdp_ram_pipe: RTL

- Parametrised successor to the team's single-clock true-dual-port RAM.
- Adds byte-enable writes, a configurable read-output pipeline with valid strobes, selectable read-during-write mode and deterministic cross-port collision handling with a flag.
- Serves as the common buffer primitive for spectrum/FRB sample storage and dual-master scratch memory.

---
 rtl/tdp_ram_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tdp_ram_pipe.sv
// True-dual-port RAM, byte enables, READ_LATENCY-cycle read pipe with valid strobes, cross-port collision flag.
// Free-running pipeline (no backpressure); `define TDP_RAM_COLLISION_CNT_EN adds a saturating collision counter.
module tdp_ram_pipe #(
   parameter int    DATA_WIDTH   = 32,
   parameter int    BYTE_WIDTH   = 8,
   parameter int    ADDR_WIDTH   = 10,
   parameter int    READ_LATENCY = 2,
   parameter string RDW_MODE     = "WRITE_FIRST",
   parameter bit    PRIORITY_A   = 1'b1,
   localparam int   NB           = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_a,
   input  logic [NB-1:0]         we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   output logic                  dout_valid_a,
   input  logic                  en_b,
   input  logic [NB-1:0]         we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b,
   output logic                  dout_valid_b,
   output logic                  collision
`ifdef TDP_RAM_COLLISION_CNT_EN
   ,
   input  logic                  collision_cnt_clr,
   output logic [15:0]           collision_cnt
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int MODE  = (RDW_MODE == "READ_FIRST") ? 1 : (RDW_MODE == "NO_CHANGE") ? 2 : 0;
   // Port index that is written last, and therefore wins overlapping lanes
   localparam int HI    = PRIORITY_A ? 0 : 1;
   localparam int LO    = 1 - HI;

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
         $error("tdp_ram_pipe: READ_LATENCY must be 1..3");
      end
      if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
         $error("tdp_ram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
      if (RDW_MODE != "WRITE_FIRST" && RDW_MODE != "READ_FIRST" && RDW_MODE != "NO_CHANGE") begin : g_bad_mode
         $error("tdp_ram_pipe: unknown RDW_MODE");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  en_p   [2];
   logic [NB-1:0]         we_p   [2];
   logic [NB-1:0]         wr_p   [2];
   logic [ADDR_WIDTH-1:0] addr_p [2];
   logic [DATA_WIDTH-1:0] din_p  [2];

   assign en_p[0]   = en_a;
   assign en_p[1]   = en_b;
   assign we_p[0]   = we_a;
   assign we_p[1]   = we_b;
   assign addr_p[0] = addr_a;
   assign addr_p[1] = addr_b;
   assign din_p[0]  = din_a;
   assign din_p[1]  = din_b;
   assign wr_p[0]   = (en_a && !rst) ? we_a : '0;
   assign wr_p[1]   = (en_b && !rst) ? we_b : '0;

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                   input logic [DATA_WIDTH-1:0] new_w,
                                                   input logic [NB-1:0]         be);
      logic [DATA_WIDTH-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_p[LO][i]) mem[addr_p[LO]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_p[LO][i*BYTE_WIDTH +: BYTE_WIDTH];
         if (wr_p[HI][i]) mem[addr_p[HI]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_p[HI][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   logic                  acc_vld [2];
   logic [DATA_WIDTH-1:0] rd_dat  [2];
   logic                  nv   [2][READ_LATENCY];
   logic [DATA_WIDTH-1:0] nd   [2][READ_LATENCY];
   logic                  svld [2][READ_LATENCY];
   logic [DATA_WIDTH-1:0] sdat [2][READ_LATENCY];

   // Reads sample the pre-write array, so a cross-port write is never visible in the same access
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         acc_vld[p] = en_p[p] && !rst && !(MODE == 2 && (|we_p[p]));
         rd_dat[p]  = (MODE == 0) ? merge(mem[addr_p[p]], din_p[p], we_p[p]) : mem[addr_p[p]];
         nv[p][0]   = acc_vld[p];
         nd[p][0]   = rd_dat[p];
         for (int s = 1; s < READ_LATENCY; s++) begin
            nv[p][s] = svld[p][s-1];
            nd[p][s] = sdat[p][s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         for (int s = 0; s < READ_LATENCY; s++) begin
            if (rst) begin
               svld[p][s] <= 1'b0;
               sdat[p][s] <= '0;
            end else begin
               svld[p][s] <= nv[p][s];
               if (nv[p][s]) sdat[p][s] <= nd[p][s];
            end
         end
      end
   end

   assign dout_a       = sdat[0][READ_LATENCY-1];
   assign dout_valid_a = svld[0][READ_LATENCY-1];
   assign dout_b       = sdat[1][READ_LATENCY-1];
   assign dout_valid_b = svld[1][READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) collision <= 1'b0;
      else     collision <= en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
   end

`ifdef TDP_RAM_COLLISION_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || collision_cnt_clr)                 collision_cnt <= '0;
      else if (collision && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
   end
`endif

endmodule
